fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream drain stage for fifo_sync: pops bytes from the FIFO read port and serialises each byte as an 8N1 UART frame on a single tx line.
- Sits between fifo_sync and the board UART pin. Replaces the in-fabric read-side checker when bytes are to be sent off-chip.
- Reads one byte at a time. The next pop happens only after the current frame's stop bit completes.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Legal range is 2 or more; elaboration fails below 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- fifo_empty  input  1  fifo_sync empty flag
- fifo_data  input  8  fifo_sync data_out; valid the cycle after fifo_sync samples rd_en high
- fifo_rd_en  output  1  registered pop strobe to fifo_sync; one-cycle pulse per byte
- tx  output  1  serial line, idle high
- busy  output  1  high whenever state is not IDLE
- byte_count  output  16  frames fully transmitted, wraps

Behaviour:
- Reset (reset=0, takes effect immediately):
  - tx=1, fifo_rd_en=0, busy=0, byte_count=0.
  - State goes to IDLE; bit timer and bit index are cleared.
  - A partially sent byte, or one already popped, is discarded.
- FSM states: IDLE, READ, LATCH, START, DATA, STOP.
- IDLE:
  - fifo_empty is sampled only here.
  - If fifo_empty=0 at a clock edge: fifo_rd_en<=1 and go to READ.
  - Otherwise remain in IDLE with tx=1.
- READ: fifo_rd_en<=0 and go to LATCH. fifo_sync pops on this edge.
- LATCH: shift register <= fifo_data, tx<=0, timer cleared, go to START.
- START: tx=0 for exactly CLKS_PER_BIT cycles. Then tx<=shift[0], bit index=0, go to DATA.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles; bits go out LSB first.
  - After bit 7 completes: tx<=1, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - Then byte_count<=byte_count+1, with modulo-2^16 wrap (0xFFFF -> 0x0000), and go to IDLE.
- Latency: tx falls two rising edges after the edge where IDLE first samples fifo_empty=0.
- Back-to-back with FIFO non-empty: between frames, tx is high for CLKS_PER_BIT+3 cycles (stop bit, then IDLE, READ, LATCH).
- fifo_rd_en:
  - Never asserted when fifo_empty was 1 at the deciding edge.
  - Never high for two consecutive cycles.
  - Exactly one pulse per transmitted frame.
- Changes on fifo_empty or fifo_data outside IDLE/LATCH are ignored. The shift register is the only data source during a frame.
- Bit timer: counts 0..CLKS_PER_BIT-1. Its width is clog2(CLKS_PER_BIT). It restarts at each bit boundary.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (uart_pkg):
  - State enum encoding.
  - UART_START_BIT=1'b0, UART_STOP_BIT=1'b1, UART_DATA_BITS=8.
  - Default CLKS_PER_BIT constant.
- One sub-module, uart_bit_timer (parameter CLKS_PER_BIT):
  - Inputs: clk, reset, clear.
  - Output: bit_done, a one-cycle pulse on the last cycle of each bit period.
  - Same reset polarity as this block.

Test Plan (CLKS_PER_BIT=4; bench uses fifo_sync or a 1-cycle-latency FIFO model):
1. Reset:
   - Hold reset=0 with fifo_empty=0 -> tx=1, fifo_rd_en=0, busy=0, byte_count=0 throughout. No pop occurs.
2. Single byte 0xA5:
   - Exactly one fifo_rd_en pulse.
   - tx sequence in 4-cycle slots is 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop).
   - tx falls 2 edges after empty is first sampled low.
   - byte_count=1 after the stop bit; busy low afterwards.
3. Back-to-back 0x00,0x01,0x02,0x03 preloaded:
   - Four frames with correct decoded bytes.
   - tx high for 7 cycles between frames.
   - 4 rd_en pulses; byte_count=4; final state IDLE with fifo_empty=1.
4. Empty mid-frame:
   - Single byte 0x3C; bench toggles fifo_empty and changes fifo_data during DATA.
   - Transmitted byte is still 0x3C; no extra rd_en pulse.
5. Async reset mid-frame:
   - Assert reset=0 during data bit 3 between clock edges -> tx=1 and busy=0 before the next edge.
   - After release with fifo_empty=1: tx stays 1 and byte_count=0.
6. Counter wrap:
   - Stream 65537 bytes with CLKS_PER_BIT=2 -> byte_count reads 0xFFFF after 65535 frames, 0x0000 after 65536, 0x0001 after 65537.
   - Every frame decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding,
// 8N1 frame constants and the default bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } uart_state_e;

  localparam logic UART_START_BIT       = 1'b0;
  localparam logic UART_STOP_BIT        = 1'b1;
  localparam int   UART_DATA_BITS       = 8;
  localparam int   DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit period with a registered one-cycle pulse.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_period
      $error("uart_bit_timer: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_s;
  logic          bit_done_r;

  // next count: restart on clear or at the end of a bit period
  always_comb begin
    count_s = count_r;
    if (clear || (count_r == LAST)) begin
      count_s = {CW{1'b0}};
    end else begin
      count_s = count_r + CW'(1);
    end
  end

  // counter and done-pulse registers; the pulse is high while count_r == LAST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r    <= {CW{1'b0}};
      bit_done_r <= 1'b0;
    end else begin
      count_r    <= count_s;
      bit_done_r <= (count_s == LAST);
    end
  end

  assign bit_done = bit_done_r;

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains fifo_sync one byte at a time and serialises each byte as an 8N1 UART
// frame on tx; the next pop is issued only after the stop bit has completed.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] byte_count
);

  uart_state_e state_r, state_s;
  logic [7:0]  shift_r, shift_s;
  logic [2:0]  idx_r, idx_s;
  logic        tx_r, tx_s;
  logic        rd_en_r, rd_en_s;
  logic        busy_r;
  logic [15:0] count_r, count_s;
  logic        timer_clear_s;
  logic        bit_done_s;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear_s),
    .bit_done(bit_done_s)
  );

  // timer is held at zero until the start bit begins
  always_comb begin
    timer_clear_s = 1'b0;
    if ((state_r == ST_IDLE) || (state_r == ST_READ) || (state_r == ST_LATCH)) begin
      timer_clear_s = 1'b1;
    end else begin
      timer_clear_s = 1'b0;
    end
  end

  // next-state and next-output logic
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    idx_s   = idx_r;
    tx_s    = tx_r;
    rd_en_s = 1'b0;
    count_s = count_r;
    case (state_r)
      ST_IDLE: begin
        tx_s = UART_STOP_BIT;
        if (!fifo_empty) begin
          rd_en_s = 1'b1;
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        state_s = ST_LATCH;
      end
      ST_LATCH: begin
        shift_s = fifo_data;
        tx_s    = UART_START_BIT;
        state_s = ST_START;
      end
      ST_START: begin
        if (bit_done_s) begin
          tx_s    = shift_r[0];
          idx_s   = 3'd0;
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        // shift register moves right so the next bit is always at shift_r[1]
        if (bit_done_s) begin
          if (idx_r == 3'(UART_DATA_BITS - 1)) begin
            tx_s    = UART_STOP_BIT;
            state_s = ST_STOP;
          end else begin
            tx_s    = shift_r[1];
            shift_s = {1'b0, shift_r[7:1]};
            idx_s   = idx_r + 3'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (bit_done_s) begin
          count_s = count_r + 16'd1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        tx_s    = UART_STOP_BIT;
        state_s = ST_IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      shift_r <= 8'h00;
      idx_r   <= 3'd0;
      tx_r    <= UART_STOP_BIT;
      rd_en_r <= 1'b0;
      busy_r  <= 1'b0;
      count_r <= 16'h0000;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      idx_r   <= idx_s;
      tx_r    <= tx_s;
      rd_en_r <= rd_en_s;
      busy_r  <= (state_s != ST_IDLE);
      count_r <= count_s;
    end
  end

  assign fifo_rd_en = rd_en_r;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign byte_count = count_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: two instances (CLKS_PER_BIT=4 and 2) fed by 1-cycle
// latency FIFO models, a UART receiver monitor and a byte scoreboard.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  typedef struct {
    logic [7:0] data;
    bit         ok;
    int         gap;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [2] = '{1'b0, 1'b0};
  logic        fe    [2] = '{1'b1, 1'b1};
  logic [7:0]  fd    [2] = '{8'h00, 8'h00};
  logic        rd_v  [2];
  logic        tx_v  [2];
  logic        busy_v[2];
  logic [15:0] bc_v  [2];

  int errors = 0;
  int checks = 0;

  logic [7:0] fq0[$], fq1[$], exp0[$], exp1[$];
  frame_t     rx0[$], rx1[$];

  bit         ovr       = 1'b0;
  logic       ovr_empty = 1'b1;
  logic [7:0] ovr_data  = 8'h00;

  bit         inframe [2] = '{1'b0, 1'b0};
  int         pos     [2] = '{0, 0};
  int         hi_run  [2] = '{0, 0};
  int         gap_s   [2] = '{0, 0};
  int         rd_cnt  [2] = '{0, 0};
  int         dbl_rd  [2] = '{0, 0};
  int         bad_rd  [2] = '{0, 0};
  logic [7:0] sh      [2] = '{8'h00, 8'h00};
  bit         okf     [2] = '{1'b1, 1'b1};
  logic       lvl     [2] = '{1'b1, 1'b1};
  logic       prev_rd [2] = '{1'b0, 1'b0};
  logic       emp_edge[2] = '{1'b1, 1'b1};

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .reset(rst_v[0]), .fifo_empty(fe[0]), .fifo_data(fd[0]),
    .fifo_rd_en(rd_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .byte_count(bc_v[0])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .reset(rst_v[1]), .fifo_empty(fe[1]), .fifo_data(fd[1]),
    .fifo_rd_en(rd_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .byte_count(bc_v[1])
  );

  // FIFO models: pop on a sampled rd_en, data valid for the following edge
  always @(negedge clk) begin
    if (rd_v[0] === 1'b1 && fq0.size() > 0) fd[0] = fq0.pop_front();
    if (rd_v[1] === 1'b1 && fq1.size() > 0) fd[1] = fq1.pop_front();
    fe[0] = ovr ? ovr_empty : (fq0.size() == 0);
    if (ovr) fd[0] = ovr_data;
    fe[1] = (fq1.size() == 0);
  end

  // empty flag as seen by the DUT at each rising edge
  always @(posedge clk) begin
    emp_edge[0] = fe[0];
    emp_edge[1] = fe[1];
  end

  // receiver monitor: strict slot timing, LSB-first decode, rd_en bookkeeping
  always @(negedge clk) begin
    int nb, slot;
    frame_t f;
    for (int g = 0; g < 2; g++) begin
      nb = (g == 0) ? 4 : 2;
      if (rst_v[g] !== 1'b1) begin
        inframe[g] = 1'b0;
        hi_run[g]  = 0;
        prev_rd[g] = 1'b0;
      end else begin
        if (rd_v[g] === 1'b1) begin
          rd_cnt[g]++;
          if (prev_rd[g] === 1'b1) dbl_rd[g]++;
          if (emp_edge[g] === 1'b1) bad_rd[g]++;
        end
        prev_rd[g] = rd_v[g];
        if (!inframe[g]) begin
          if (tx_v[g] === 1'b0) begin
            inframe[g] = 1'b1;
            pos[g]     = 0;
            okf[g]     = 1'b1;
            gap_s[g]   = hi_run[g];
          end else begin
            hi_run[g]++;
          end
        end
        if (inframe[g]) begin
          slot = pos[g] / nb;
          if (pos[g] % nb == 0) lvl[g] = tx_v[g];
          else if (tx_v[g] !== lvl[g]) okf[g] = 1'b0;
          if (slot == 0 && tx_v[g] !== 1'b0) okf[g] = 1'b0;
          if (slot == 9 && tx_v[g] !== 1'b1) okf[g] = 1'b0;
          if (slot >= 1 && slot <= 8) sh[g][slot-1] = tx_v[g];
          pos[g]++;
          if (pos[g] == 10 * nb) begin
            inframe[g] = 1'b0;
            hi_run[g]  = nb;
            f.data = sh[g];
            f.ok   = okf[g];
            f.gap  = gap_s[g];
            if (g == 0) rx0.push_back(f);
            else        rx1.push_back(f);
          end
        end
      end
    end
  end

  task automatic wait_rx(input int g, input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if ((g == 0 && rx0.size() > 0) || (g == 1 && rx1.size() > 0)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic reset_a();
    @(negedge clk); #1;
    rst_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_v[0] = 1'b1;
    rx0.delete();
    exp0.delete();
  endtask

  task automatic test_reset();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    ovr = 1'b1; ovr_empty = 1'b0; ovr_data = 8'h5A;
    repeat (8) begin
      @(negedge clk); #1;
      checks++;
      if (tx_v[0] !== 1'b1 || rd_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || bc_v[0] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold: tx=%b rd_en=%b busy=%b byte_count=%0d, required 1 0 0 0",
                 tx_v[0], rd_v[0], busy_v[0], bc_v[0]);
      end
    end
    ovr_empty = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_v[0] = 1'b1;
    ovr = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rd_cnt[0] !== 0) begin
      errors++;
      $display("FAIL reset_idle: tx=%b busy=%b pops=%0d, required 1 0 0", tx_v[0], busy_v[0], rd_cnt[0]);
    end
  endtask

  task automatic test_single_byte();
    int n, rd0;
    bit got;
    frame_t f;
    logic [7:0] e;
    reset_a();
    rd0 = rd_cnt[0];
    @(negedge clk); #1;
    fq0.push_back(8'hA5); exp0.push_back(8'hA5);
    @(negedge clk); #1;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (tx_v[0] !== 1'b0 && n < 20);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL single_latency: tx fell at sample %0d, required 3", n);
    end
    wait_rx(0, 100, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL single_frame: no frame received, required 1");
    end else begin
      f = rx0.pop_front(); e = exp0.pop_front();
      checks++;
      if (f.data !== e || !f.ok) begin
        errors++;
        $display("FAIL single_data: got %h ok=%0d, required %h ok=1", f.data, f.ok, e);
      end
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bc_v[0] !== 16'd1 || busy_v[0] !== 1'b0 || rd_cnt[0] - rd0 != 1) begin
      errors++;
      $display("FAIL single_after: byte_count=%0d busy=%b pulses=%0d, required 1 0 1",
               bc_v[0], busy_v[0], rd_cnt[0] - rd0);
    end
  endtask

  task automatic test_back_to_back();
    int rd0;
    bit got;
    frame_t f;
    logic [7:0] e;
    reset_a();
    rd0 = rd_cnt[0];
    for (int i = 0; i < 4; i++) begin
      fq0.push_back(8'(i)); exp0.push_back(8'(i));
    end
    for (int k = 0; k < 4; k++) begin
      wait_rx(0, 150, got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL b2b_timeout: frame %0d missing", k);
        break;
      end
      f = rx0.pop_front(); e = exp0.pop_front();
      checks++;
      if (f.data !== e || !f.ok) begin
        errors++;
        $display("FAIL b2b_data: frame %0d got %h ok=%0d, required %h ok=1", k, f.data, f.ok, e);
      end
      if (k > 0) begin
        checks++;
        if (f.gap != 7) begin
          errors++;
          $display("FAIL b2b_gap: frame %0d idle-high %0d cycles, required 7", k, f.gap);
        end
      end
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bc_v[0] !== 16'd4 || busy_v[0] !== 1'b0 || fe[0] !== 1'b1 || rd_cnt[0] - rd0 != 4) begin
      errors++;
      $display("FAIL b2b_after: byte_count=%0d busy=%b empty=%b pulses=%0d, required 4 0 1 4",
               bc_v[0], busy_v[0], fe[0], rd_cnt[0] - rd0);
    end
  endtask

  task automatic test_empty_midframe();
    int rd0, n;
    bit got;
    frame_t f;
    logic [7:0] e;
    reset_a();
    rd0 = rd_cnt[0];
    fq0.push_back(8'h3C); exp0.push_back(8'h3C);
    n = 0;
    while (!(inframe[0] && pos[0] >= 10) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    ovr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ovr_empty = i[0];
      ovr_data  = 8'($urandom_range(255, 0));
      @(negedge clk); #1;
    end
    ovr = 1'b0;
    wait_rx(0, 100, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL midframe_frame: no frame received, required 1");
    end else begin
      f = rx0.pop_front(); e = exp0.pop_front();
      checks++;
      if (f.data !== e || !f.ok) begin
        errors++;
        $display("FAIL midframe_data: got %h ok=%0d, required %h ok=1", f.data, f.ok, e);
      end
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (rd_cnt[0] - rd0 != 1 || bc_v[0] !== 16'd1 || rx0.size() != 0) begin
      errors++;
      $display("FAIL midframe_pulses: pulses=%0d byte_count=%0d extra_frames=%0d, required 1 1 0",
               rd_cnt[0] - rd0, bc_v[0], rx0.size());
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit low_seen;
    reset_a();
    fq0.push_back(8'h96); exp0.push_back(8'h96);
    n = 0;
    while (!(inframe[0] && pos[0] == 17) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (tx_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_bit3: tx=%b before reset, required 0", tx_v[0]);
    end
    rst_v[0] = 1'b0;
    #1;
    checks++;
    if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || bc_v[0] !== 16'd0 || rd_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_immediate: tx=%b busy=%b byte_count=%0d rd_en=%b, required 1 0 0 0",
               tx_v[0], busy_v[0], bc_v[0], rd_v[0]);
    end
    @(negedge clk); #1;
    rst_v[0] = 1'b1;
    exp0.delete();
    low_seen = 1'b0;
    repeat (60) begin
      @(negedge clk); #1;
      if (tx_v[0] !== 1'b1) low_seen = 1'b1;
    end
    checks++;
    if (low_seen || bc_v[0] !== 16'd0 || rx0.size() != 0 || busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_after: tx_low=%0d byte_count=%0d frames=%0d busy=%b, required 0 0 0 0",
               low_seen, bc_v[0], rx0.size(), busy_v[0]);
    end
  endtask

  task automatic test_counter_wrap();
    bit got;
    frame_t f;
    logic [7:0] e;
    logic [15:0] want;
    @(negedge clk); #1;
    rst_v[1] = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      fq1.push_back(8'(i * 7 + 3)); exp1.push_back(8'(i * 7 + 3));
    end
    for (int k = 1; k <= 65537; k++) begin
      wait_rx(1, 100, got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL wrap_timeout: frame %0d missing", k);
        break;
      end
      f = rx1.pop_front(); e = exp1.pop_front();
      checks++;
      if (f.data !== e || !f.ok) begin
        errors++;
        $display("FAIL wrap_data: frame %0d got %h ok=%0d, required %h ok=1", k, f.data, f.ok, e);
      end
      @(negedge clk); #1;
      if (k >= 65535) begin
        want = 16'(k);
        checks++;
        if (bc_v[1] !== want) begin
          errors++;
          $display("FAIL wrap_count: after %0d frames byte_count=%h, required %h", k, bc_v[1], want);
        end
      end
    end
    checks++;
    if (rd_cnt[1] != 65537 || dbl_rd[1] != 0 || bad_rd[1] != 0) begin
      errors++;
      $display("FAIL wrap_pulses: pulses=%0d double=%0d when_empty=%0d, required 65537 0 0",
               rd_cnt[1], dbl_rd[1], bad_rd[1]);
    end
  endtask

  task automatic test_rd_rules();
    checks++;
    if (dbl_rd[0] != 0 || bad_rd[0] != 0) begin
      errors++;
      $display("FAIL rd_rules: double=%0d when_empty=%0d, required 0 0", dbl_rd[0], bad_rd[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty_midframe();
    test_async_reset();
    test_rd_rules();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
